// File: rtl/ysyx_23060077_riscv_core_ctrl.sv
// Multi-cycle instruction sequencer: FETCH -> EXEC -> (MEM) -> WB, with
// instret counter and bus watchdog that parks the core in ERR on a lost ack.
module ysyx_23060077_riscv_core_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_WIDTH      = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 ifu_req_o,
    input  logic                 ifu_ack_i,
    input  logic                 dec_load_i,
    input  logic                 dec_store_i,
    input  logic                 dec_rd_wen_i,
    input  logic                 dec_csr_i,
    input  logic                 dec_ebreak_i,
    input  logic                 dec_illegal_i,
    input  logic                 jump_valid_i,
    output logic                 lsu_req_o,
    input  logic                 lsu_ack_i,
    output logic                 rf_wen_o,
    output logic                 csr_wen_o,
    output logic                 pc_wen_o,
    output logic                 pc_sel_o,
    output logic                 commit_o,
    output logic [CNT_WIDTH-1:0] instret_o,
    output logic                 halt_o,
    output logic                 err_o,
    output logic [1:0]           err_code_o
);

    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ERR_FETCH   = 2'b01;
    localparam logic [1:0] ERR_MEM     = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_EXEC, S_MEM, S_WB, S_HALT, S_ERR
    } state_e;

    state_e                state_q, state_d;
    logic [WD_W-1:0]       wdog_q, wdog_d;
    logic [CNT_WIDTH-1:0]  instret_q, instret_d;
    logic [1:0]            err_code_q, err_code_d;
    logic                  ifu_req_q, lsu_req_q, wb_q, halt_q, err_q;

    // Next-state logic; wdog only survives while staying in FETCH/MEM
    always_comb begin
        state_d    = state_q;
        err_code_d = err_code_q;
        wdog_d     = '0;
        instret_d  = instret_q;
        unique case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                if (ifu_ack_i) begin
                    state_d = S_EXEC;
                end else if (wdog_q == WD_LAST) begin
                    state_d    = S_ERR;
                    err_code_d = ERR_FETCH;
                end else begin
                    wdog_d = wdog_q + WD_W'(1);
                end
            end
            S_EXEC: begin
                if (dec_illegal_i) begin
                    state_d    = S_ERR;
                    err_code_d = ERR_ILLEGAL;
                end else if (dec_ebreak_i) begin
                    state_d = S_HALT;
                end else if (dec_load_i || dec_store_i) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (lsu_ack_i) begin
                    state_d = S_WB;
                end else if (wdog_q == WD_LAST) begin
                    state_d    = S_ERR;
                    err_code_d = ERR_MEM;
                end else begin
                    wdog_d = wdog_q + WD_W'(1);
                end
            end
            S_WB: begin
                state_d   = S_FETCH;
                instret_d = instret_q + CNT_WIDTH'(1);
            end
            S_HALT:  state_d = S_HALT;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_ERR;
        endcase
    end

    // State and registered state-decoded flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            wdog_q     <= '0;
            instret_q  <= '0;
            err_code_q <= '0;
            ifu_req_q  <= 1'b0;
            lsu_req_q  <= 1'b0;
            wb_q       <= 1'b0;
            halt_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wdog_q     <= wdog_d;
            instret_q  <= instret_d;
            err_code_q <= err_code_d;
            ifu_req_q  <= (state_d == S_FETCH);
            lsu_req_q  <= (state_d == S_MEM);
            wb_q       <= (state_d == S_WB);
            halt_q     <= (state_d == S_HALT);
            err_q      <= (state_d == S_ERR);
        end
    end

    assign ifu_req_o  = ifu_req_q;
    assign lsu_req_o  = lsu_req_q;
    assign halt_o     = halt_q;
    assign err_o      = err_q;
    assign err_code_o = err_code_q;
    assign instret_o  = instret_q;

    // WB strobes qualify the WB state flag with the current decode
    assign rf_wen_o  = wb_q & dec_rd_wen_i & ~dec_store_i;
    assign csr_wen_o = wb_q & dec_csr_i;
    assign pc_wen_o  = wb_q;
    assign pc_sel_o  = wb_q & jump_valid_i;
    assign commit_o  = wb_q;

endmodule

// File: tb/tb_ysyx_23060077_riscv_core_ctrl.sv
// Directed bench for the core sequencer with a short watchdog (TIMEOUT_CYCLES=8).
module tb_ysyx_23060077_riscv_core_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ifu_req, ifu_ack;
    logic        d_load, d_store, d_rdw, d_csr, d_ebreak, d_illegal, jmp;
    logic        lsu_req, lsu_ack;
    logic        rf_wen, csr_wen, pc_wen, pc_sel, commit;
    logic [63:0] instret;
    logic        halt, err;
    logic [1:0]  err_code;

    int vectors    = 0;
    int miscompares = 0;
    int ncommit;

    ysyx_23060077_riscv_core_ctrl #(.TIMEOUT_CYCLES(8), .CNT_WIDTH(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .ifu_req_o(ifu_req), .ifu_ack_i(ifu_ack),
        .dec_load_i(d_load), .dec_store_i(d_store), .dec_rd_wen_i(d_rdw),
        .dec_csr_i(d_csr), .dec_ebreak_i(d_ebreak), .dec_illegal_i(d_illegal),
        .jump_valid_i(jmp),
        .lsu_req_o(lsu_req), .lsu_ack_i(lsu_ack),
        .rf_wen_o(rf_wen), .csr_wen_o(csr_wen), .pc_wen_o(pc_wen), .pc_sel_o(pc_sel),
        .commit_o(commit), .instret_o(instret),
        .halt_o(halt), .err_o(err), .err_code_o(err_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_dec(input logic ld, input logic st, input logic rw, input logic cs,
                           input logic eb, input logic il, input logic jp);
        d_load = ld; d_store = st; d_rdw = rw; d_csr = cs;
        d_ebreak = eb; d_illegal = il; jmp = jp;
    endtask

    // Leaves the DUT in its first FETCH cycle
    task automatic do_reset();
        ifu_ack = 1'b0; lsu_ack = 1'b0;
        set_dec(0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // From FETCH cycle 1: immediate ack, runs one non-memory inst back to FETCH
    task automatic run_alu();
        ifu_ack = 1'b1;
        tick();
        ifu_ack = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        rst_n = 1'b0; ifu_ack = 1'b0; lsu_ack = 1'b0;
        set_dec(0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        chk("rst_ifu_req", 64'(ifu_req), 64'd0);
        chk("rst_instret", instret, 64'd0);
        chk("rst_flags", 64'({halt, err, err_code, commit, pc_wen}), 64'd0);

        // Release mid-cycle: one IDLE cycle, then FETCH
        #2 rst_n = 1'b1;
        #1 chk("idle_ifu_req", 64'(ifu_req), 64'd0);
        tick();
        chk("fetch1_ifu_req", 64'(ifu_req), 64'd1);

        // ALU inst with rd write, immediate ack
        set_dec(0, 0, 1, 0, 0, 0, 0);
        ifu_ack = 1'b1;
        tick();
        ifu_ack = 1'b0;
        chk("exec_ifu_req", 64'(ifu_req), 64'd0);
        chk("exec_strobes", 64'({rf_wen, pc_wen, commit}), 64'd0);
        tick();
        chk("alu_wb_rf_wen", 64'(rf_wen), 64'd1);
        chk("alu_wb_pc", 64'({pc_wen, pc_sel}), 64'b10);
        chk("alu_wb_commit", 64'(commit), 64'd1);
        tick();
        chk("alu_ifu_req_again", 64'(ifu_req), 64'd1);
        chk("alu_instret", instret, 64'd1);
        chk("alu_commit_drop", 64'(commit), 64'd0);

        // Load, lsu ack 5 cycles after MEM entry
        set_dec(1, 0, 1, 0, 0, 0, 0);
        ifu_ack = 1'b1;
        tick();
        ifu_ack = 1'b0;
        tick();
        for (int k = 0; k < 6; k++) begin
            chk("load_lsu_req", 64'(lsu_req), 64'd1);
            if (k == 5) lsu_ack = 1'b1;
            tick();
        end
        lsu_ack = 1'b0;
        chk("load_wb_lsu_req", 64'(lsu_req), 64'd0);
        chk("load_wb_rf_wen", 64'(rf_wen), 64'd1);
        chk("load_wb_commit", 64'(commit), 64'd1);
        tick();
        chk("load_instret", instret, 64'd2);

        // Store: rd write masked
        set_dec(0, 1, 1, 0, 0, 0, 0);
        ifu_ack = 1'b1;
        tick();
        ifu_ack = 1'b0;
        tick();
        lsu_ack = 1'b1;
        tick();
        lsu_ack = 1'b0;
        chk("store_wb_rf_wen", 64'(rf_wen), 64'd0);
        chk("store_wb_commit", 64'(commit), 64'd1);
        tick();

        // CSR write
        set_dec(0, 0, 1, 1, 0, 0, 0);
        ifu_ack = 1'b1;
        tick();
        ifu_ack = 1'b0;
        tick();
        chk("csr_wb_csr_wen", 64'(csr_wen), 64'd1);
        tick();

        // Taken branch
        set_dec(0, 0, 0, 0, 0, 0, 1);
        ifu_ack = 1'b1;
        tick();
        ifu_ack = 1'b0;
        tick();
        chk("br_wb_pc_sel", 64'(pc_sel), 64'd1);
        chk("br_wb_rf_wen", 64'(rf_wen), 64'd0);
        tick();
        chk("br_instret", instret, 64'd5);

        // Fetch ack on the 8th FETCH cycle is accepted
        set_dec(0, 0, 1, 0, 0, 0, 0);
        for (int i = 1; i < 8; i++) tick();
        chk("f8_ifu_req", 64'(ifu_req), 64'd1);
        ifu_ack = 1'b1;
        tick();
        ifu_ack = 1'b0;
        chk("f8_no_err", 64'({err, ifu_req}), 64'd0);
        tick();
        chk("f8_commit", 64'(commit), 64'd1);
        tick();

        // Mem ack on the 8th MEM cycle is accepted
        set_dec(1, 0, 1, 0, 0, 0, 0);
        ifu_ack = 1'b1;
        tick();
        ifu_ack = 1'b0;
        tick();
        for (int i = 1; i < 8; i++) tick();
        chk("m8_lsu_req", 64'(lsu_req), 64'd1);
        lsu_ack = 1'b1;
        tick();
        lsu_ack = 1'b0;
        chk("m8_no_err", 64'({err, commit}), 64'b01);
        tick();
        chk("m8_instret", instret, 64'd7);

        // Async reset mid-MEM
        ifu_ack = 1'b1;
        tick();
        ifu_ack = 1'b0;
        tick();
        tick();
        chk("pre_rst_lsu_req", 64'(lsu_req), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_lsu_req", 64'(lsu_req), 64'd0);
        chk("async_rst_instret", instret, 64'd0);
        tick();
        rst_n = 1'b1;
        set_dec(0, 0, 1, 0, 0, 0, 0);
        chk("post_rst_idle", 64'(ifu_req), 64'd0);
        tick();
        chk("post_rst_fetch", 64'(ifu_req), 64'd1);

        // Ten back-to-back ALU insts
        ncommit = 0;
        for (int n = 0; n < 10; n++) begin
            ifu_ack = 1'b1;
            tick();
            ifu_ack = 1'b0;
            if (commit) ncommit++;
            tick();
            if (commit) ncommit++;
            tick();
            if (commit) ncommit++;
        end
        chk("b2b_commits", 64'(ncommit), 64'd10);
        chk("b2b_instret", instret, 64'd10);

        // Illegal beats ebreak
        set_dec(0, 0, 1, 0, 1, 1, 0);
        ifu_ack = 1'b1;
        tick();
        ifu_ack = 1'b0;
        tick();
        chk("ill_err", 64'({err, halt}), 64'b10);
        chk("ill_code", 64'(err_code), 64'd3);
        chk("ill_instret", instret, 64'd10);
        tick();
        chk("ill_sticky", 64'({err, ifu_req, pc_wen}), 64'b100);

        // Ebreak alone halts, not counted
        do_reset();
        set_dec(0, 0, 1, 0, 0, 0, 0);
        run_alu();
        set_dec(0, 0, 0, 0, 1, 0, 0);
        ifu_ack = 1'b1;
        tick();
        ifu_ack = 1'b0;
        tick();
        chk("ebreak_halt", 64'({halt, err}), 64'b10);
        chk("ebreak_instret", instret, 64'd1);
        tick();
        chk("ebreak_sticky", 64'({halt, ifu_req, commit}), 64'b100);

        // Fetch timeout
        do_reset();
        for (int i = 1; i < 8; i++) tick();
        chk("fto_last_fetch", 64'({ifu_req, err}), 64'b10);
        tick();
        chk("fto_err", 64'({err, ifu_req}), 64'b10);
        chk("fto_code", 64'(err_code), 64'd1);
        ifu_ack = 1'b1;
        tick();
        ifu_ack = 1'b0;
        tick();
        chk("fto_late_ack", 64'({err, err_code, ifu_req}), 64'b1010);

        // Mem timeout
        do_reset();
        set_dec(1, 0, 1, 0, 0, 0, 0);
        ifu_ack = 1'b1;
        tick();
        ifu_ack = 1'b0;
        tick();
        for (int i = 1; i < 8; i++) tick();
        chk("mto_last_mem", 64'({lsu_req, err}), 64'b10);
        tick();
        chk("mto_err", 64'({err, lsu_req}), 64'b10);
        chk("mto_code", 64'(err_code), 64'd2);
        lsu_ack = 1'b1;
        tick();
        lsu_ack = 1'b0;
        tick();
        chk("mto_late_ack", 64'({err, err_code, commit, instret[0]}), 64'b11000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
